matmul_tile_mem_seq: RTL
========================

Name: matmul_tile_mem_seq

Overview:
- Parametrised memory subsystem and sequencer for a TILE_ROWS x TILE_COLS grid of systolic matmul tiles.
- Owns the A banks (one per tile row), the B banks (one per tile column) and the C banks (one per tile row).
- Arbitrates host load/readout against compute and streams A/B words to the tile grid over k_len beats.
- Captures result rows from the grid into the C banks. Sits between the host port and the tile-grid engine; replaces the fixed 2x2 address-mux wrapper.

Parameters:
- DWIDTH, 16, element width (fp16)
- LANES, 4, elements per memory word (tile edge)
- AWIDTH, 7, bank address width; bank depth is 2**AWIDTH
- TILE_ROWS, 2, tile rows = number of A banks = number of C banks
- TILE_COLS, 2, tile columns = number of B banks
- BSEL_W, 3, host bank-select width; must satisfy 2**BSEL_W >= 2*TILE_ROWS+TILE_COLS

Ports:
- clk_mem  in  1  clock
- reset  in  1  synchronous, active-high
- host_we  in  1  host write strobe
- host_re  in  1  host read strobe
- host_bank  in  BSEL_W  bank select: 0..TR-1 = A; TR..TR+TC-1 = B; TR+TC..2TR+TC-1 = C
- host_addr  in  AWIDTH  host word address
- host_wdata  in  LANES*DWIDTH  host write data
- host_rdata  out  LANES*DWIDTH  host read data
- host_rvalid  out  1  host read data valid
- host_err  out  1  one-cycle pulse when a host access is dropped
- start  in  1  compute start pulse
- k_len  in  AWIDTH+1  number of A/B beats to stream, 0..2**AWIDTH
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- a_stream  out  TILE_ROWS*LANES*DWIDTH  A words to the grid, bank r in slice r
- b_stream  out  TILE_COLS*LANES*DWIDTH  B words to the grid, bank c in slice c
- stream_valid  out  1  a_stream/b_stream valid
- stream_last  out  1  marks the final beat
- c_in  in  TILE_ROWS*LANES*DWIDTH  result rows from the grid
- c_in_valid  in  1  result beat strobe
- eng_done  in  1  grid finished

Behaviour:
- Reset: FSM to IDLE; all address counters cleared; every output = 0. RAM contents are retained, not cleared. Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with k_len!=0 -> STREAM. start=1 with k_len==0 -> DONE.
  - busy=1 in every state except IDLE. start outside IDLE is ignored.
- STREAM:
  - Read address rd_addr runs 0..k_len-1, one per cycle, into all A and B banks in parallel.
  - Bank read latency is 1 cycle, followed by an output register. If start is sampled at cycle T, address 0 issues at T+1 and the first stream_valid occurs at T+3.
  - Exactly k_len consecutive beats; stream_last is asserted with beat k_len-1.
  - The FSM moves to DRAIN once the last address has issued; the pipeline flushes the remaining beats.
  - k_len = 2**AWIDTH streams the full bank, with no address wrap issue.
- DRAIN:
  - Each c_in_valid beat writes slice r of c_in into C bank r at c_wr_addr, which starts at 0 and increments per beat, wrapping at 2**AWIDTH.
  - eng_done -> DONE. A beat coincident with eng_done is still written.
  - c_in_valid in any other state is ignored.
- DONE: done=1 for one cycle, busy drops the same cycle, then -> IDLE.
- Host port:
  - Accepted only in IDLE.
  - Write: 1-cycle write into the selected A or B bank. A write selecting a C bank or an unused code is dropped and pulses host_err.
  - Read: any bank; host_rdata and host_rvalid appear 2 cycles after host_re. host_rdata holds its value until the next read.
  - Any host access while busy is dropped and pulses host_err.
  - host_we and host_re in the same cycle: the write wins, the read is dropped, host_err pulses.
  - start with host_we/host_re in the same cycle: start wins, the access is dropped, host_err pulses.
  - A read already in flight when start arrives still completes.

Optional Feature:
- Macro: MATMUL_TILE_MEM_SEQ_CYCLE_COUNT_EN.
- When defined:
  - Adds output perf_cycles [31:0], counting clk_mem cycles from start acceptance through DONE inclusive.
  - Saturates at 32'hFFFFFFFF. Cleared at start acceptance; holds its value in IDLE. Reset value is 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Load: host writes bank0 addr 3 = 64'h3C00_4000_4200_4400, then reads it -> host_rvalid exactly 2 cycles after host_re with the same data; host_err=0.
2. Stream: A0/A1/B0/B1 preloaded with addr index patterns, start with k_len=8 at T -> stream_valid T+3..T+10, beat i carries word i of every bank, stream_last at T+10.
3. Writeback: in DRAIN, 4 c_in_valid beats with eng_done on the 4th -> C0/C1 addresses 0..3 written; done pulses once; busy=0 the same cycle; host readback of C matches.
4. Conflicts: host_we during STREAM -> host_err pulse and bank unchanged; host_we+host_re together in IDLE -> write lands, no rvalid; write to a C bank -> host_err.
5. Boundaries: k_len=0 -> done 2 cycles after start with no stream_valid; k_len=128 -> 128 beats with stream_last on the last; reset asserted mid-STREAM -> outputs 0, no done, RAM data preserved.
6. With CYCLE_COUNT_EN, k_len=8 and eng_done 5 cycles after the last beat -> perf_cycles equals the measured start-to-done count and holds in IDLE.

Source files
------------

// File: rtl/matmul_tile_mem_seq_if.sv
// Host access port of the matmul tile memory subsystem.
// master = host side, slave = memory subsystem side.
interface matmul_tile_mem_seq_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned AWIDTH = 7,
  parameter int unsigned BSEL_W = 3
);

  logic                    host_we;
  logic                    host_re;
  logic [BSEL_W-1:0]       host_bank;
  logic [AWIDTH-1:0]       host_addr;
  logic [LANES*DWIDTH-1:0] host_wdata;
  logic [LANES*DWIDTH-1:0] host_rdata;
  logic                    host_rvalid;
  logic                    host_err;

  modport master (
    output host_we,
    output host_re,
    output host_bank,
    output host_addr,
    output host_wdata,
    input  host_rdata,
    input  host_rvalid,
    input  host_err
  );

  modport slave (
    input  host_we,
    input  host_re,
    input  host_bank,
    input  host_addr,
    input  host_wdata,
    output host_rdata,
    output host_rvalid,
    output host_err
  );

endinterface

// File: rtl/matmul_tile_mem_seq.sv
// Memory subsystem and sequencer for a TILE_ROWS x TILE_COLS systolic matmul grid.
// Owns A banks (per tile row), B banks (per tile column) and C banks (per tile row).
// Host load/readout is only served while idle; compute streams k_len A/B beats to
// the grid and then captures result rows into the C banks until eng_done.
// Optional: define MATMUL_TILE_MEM_SEQ_CYCLE_COUNT_EN to add the perf_cycles counter.
module matmul_tile_mem_seq #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned AWIDTH    = 7,
  parameter int unsigned TILE_ROWS = 2,
  parameter int unsigned TILE_COLS = 2,
  parameter int unsigned BSEL_W    = 3
) (
  input  logic                              clk_mem,
  input  logic                              reset,
  matmul_tile_mem_seq_if.slave              host,
  input  logic                              start,
  input  logic [AWIDTH:0]                   k_len,
  output logic                              busy,
  output logic                              done,
  output logic [TILE_ROWS*LANES*DWIDTH-1:0] a_stream,
  output logic [TILE_COLS*LANES*DWIDTH-1:0] b_stream,
  output logic                              stream_valid,
  output logic                              stream_last,
  input  logic [TILE_ROWS*LANES*DWIDTH-1:0] c_in,
  input  logic                              c_in_valid,
  input  logic                              eng_done
`ifdef MATMUL_TILE_MEM_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]                       perf_cycles
`endif
);

  localparam int unsigned WordW = LANES * DWIDTH;
  localparam int unsigned Depth = 2 ** AWIDTH;
  // One extra bit so the end-of-range code never aliases to zero.
  localparam int unsigned SelW  = BSEL_W + 1;
  localparam logic [SelW-1:0] BankB   = SelW'(TILE_ROWS);
  localparam logic [SelW-1:0] BankC   = SelW'(TILE_ROWS + TILE_COLS);
  localparam logic [SelW-1:0] BankEnd = SelW'(2 * TILE_ROWS + TILE_COLS);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

  // Sequencer state
  state_e            state_q, state_d;
  logic [AWIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [AWIDTH:0]   k_len_q;
  logic [AWIDTH-1:0] c_wr_addr_q;
  logic              start_acc;
  logic              issue_last;
  logic              c_wr_en;

  // Host decode
  logic [SelW-1:0]      bank_ext;
  logic                 host_in_a, host_in_b, host_in_c;
  logic                 host_open;
  logic                 host_wr_ok, host_rd_ok, host_err_d;
  logic [TILE_ROWS-1:0] a_wr_en;
  logic [TILE_COLS-1:0] b_wr_en;

  // Storage and read data registers
  logic [WordW-1:0]  a_mem [TILE_ROWS][Depth];
  logic [WordW-1:0]  b_mem [TILE_COLS][Depth];
  logic [WordW-1:0]  c_mem [TILE_ROWS][Depth];
  logic [WordW-1:0]  a_rd_q [TILE_ROWS];
  logic [WordW-1:0]  b_rd_q [TILE_COLS];
  logic [WordW-1:0]  c_rd_q [TILE_ROWS];
  logic [AWIDTH-1:0] ab_rd_addr;

  // Pipelines and registered outputs
  logic                              p1_valid_q, p1_last_q;
  logic                              hrd_valid_q;
  logic [SelW-1:0]                   hrd_bank_q;
  logic [WordW-1:0]                  host_sel;
  logic [WordW-1:0]                  host_rdata_q;
  logic                              host_rvalid_q, host_err_q;
  logic                              busy_q, done_q;
  logic                              stream_valid_q, stream_last_q;
  logic [TILE_ROWS*LANES*DWIDTH-1:0] a_stream_q;
  logic [TILE_COLS*LANES*DWIDTH-1:0] b_stream_q;

  assign start_acc  = (state_q == StIdle) && start;
  assign issue_last = (rd_cnt_q == (k_len_q - 1'b1));
  assign c_wr_en    = (state_q == StDrain) && c_in_valid;

  // Next-state and read-address counter
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_cnt_d = '0;
          state_d  = (k_len == '0) ? StDone : StStream;
        end
      end
      StStream: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (issue_last) state_d = StDrain;
      end
      StDrain: begin
        if (eng_done) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer registers; C write pointer restarts with every accepted start
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      k_len_q     <= '0;
      c_wr_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      if (start_acc) begin
        k_len_q     <= k_len;
        c_wr_addr_q <= '0;
      end else if (c_wr_en) begin
        c_wr_addr_q <= c_wr_addr_q + 1'b1;
      end
    end
  end

  assign bank_ext = {1'b0, host.host_bank};

  // Host access arbitration: start and busy both win over the host
  always_comb begin
    a_wr_en    = '0;
    b_wr_en    = '0;
    host_in_a  = (bank_ext < BankB);
    host_in_b  = (bank_ext >= BankB) && (bank_ext < BankC);
    host_in_c  = (bank_ext >= BankC) && (bank_ext < BankEnd);
    host_open  = (state_q == StIdle) && !start;
    host_wr_ok = host_open && host.host_we && (host_in_a || host_in_b);
    host_rd_ok = host_open && host.host_re && !host.host_we &&
                 (host_in_a || host_in_b || host_in_c);
    host_err_d = (host.host_we && !host_wr_ok) || (host.host_re && !host_rd_ok);
    for (int r = 0; r < TILE_ROWS; r++) begin
      a_wr_en[r] = host_wr_ok && (bank_ext == SelW'(r));
    end
    for (int c = 0; c < TILE_COLS; c++) begin
      b_wr_en[c] = host_wr_ok && (bank_ext == SelW'(TILE_ROWS + c));
    end
  end

  // A/B read port is shared: the stream owns it in STREAM, the host otherwise
  assign ab_rd_addr = (state_q == StStream) ? rd_cnt_q[AWIDTH-1:0] : host.host_addr;

  // A/B banks: host write port, registered read port (contents survive reset)
  always_ff @(posedge clk_mem) begin
    for (int r = 0; r < TILE_ROWS; r++) begin
      if (a_wr_en[r]) a_mem[r][host.host_addr] <= host.host_wdata;
      a_rd_q[r] <= a_mem[r][ab_rd_addr];
    end
    for (int c = 0; c < TILE_COLS; c++) begin
      if (b_wr_en[c]) b_mem[c][host.host_addr] <= host.host_wdata;
      b_rd_q[c] <= b_mem[c][ab_rd_addr];
    end
  end

  // C banks: grid write port, host read port
  always_ff @(posedge clk_mem) begin
    for (int r = 0; r < TILE_ROWS; r++) begin
      if (c_wr_en) c_mem[r][c_wr_addr_q] <= c_in[r*WordW +: WordW];
      c_rd_q[r] <= c_mem[r][host.host_addr];
    end
  end

  // Select the bank addressed by the host read issued last cycle
  always_comb begin
    host_sel = '0;
    for (int r = 0; r < TILE_ROWS; r++) begin
      if (hrd_bank_q == SelW'(r)) host_sel = a_rd_q[r];
    end
    for (int c = 0; c < TILE_COLS; c++) begin
      if (hrd_bank_q == SelW'(TILE_ROWS + c)) host_sel = b_rd_q[c];
    end
    for (int r = 0; r < TILE_ROWS; r++) begin
      if (hrd_bank_q == SelW'(TILE_ROWS + TILE_COLS + r)) host_sel = c_rd_q[r];
    end
  end

  // Host read pipeline: bank read, then output register (rdata holds between reads)
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      hrd_valid_q   <= 1'b0;
      hrd_bank_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_err_q    <= 1'b0;
    end else begin
      hrd_valid_q   <= host_rd_ok;
      if (host_rd_ok) hrd_bank_q <= bank_ext;
      host_rvalid_q <= hrd_valid_q;
      if (hrd_valid_q) host_rdata_q <= host_sel;
      host_err_q    <= host_err_d;
    end
  end

  // Stream pipeline: address issue -> bank read -> output register
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      p1_valid_q     <= 1'b0;
      p1_last_q      <= 1'b0;
      stream_valid_q <= 1'b0;
      stream_last_q  <= 1'b0;
      a_stream_q     <= '0;
      b_stream_q     <= '0;
    end else begin
      p1_valid_q     <= (state_q == StStream);
      p1_last_q      <= (state_q == StStream) && issue_last;
      stream_valid_q <= p1_valid_q;
      stream_last_q  <= p1_last_q;
      if (p1_valid_q) begin
        for (int r = 0; r < TILE_ROWS; r++) a_stream_q[r*WordW +: WordW] <= a_rd_q[r];
        for (int c = 0; c < TILE_COLS; c++) b_stream_q[c*WordW +: WordW] <= b_rd_q[c];
      end
    end
  end

  // Status outputs; done trails the DONE state so busy falls in the same cycle
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != StIdle);
      done_q <= (state_q == StDone);
    end
  end

`ifdef MATMUL_TILE_MEM_SEQ_CYCLE_COUNT_EN
  logic [31:0] perf_q;

  // Cycle counter: the accepting cycle counts as 1, then every non-idle cycle
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= 32'd1;
    end else if ((state_q != StIdle) && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign a_stream         = a_stream_q;
  assign b_stream         = b_stream_q;
  assign stream_valid     = stream_valid_q;
  assign stream_last      = stream_last_q;
  assign host.host_rdata  = host_rdata_q;
  assign host.host_rvalid = host_rvalid_q;
  assign host.host_err    = host_err_q;

endmodule
